// File: rtl/mpu_dmem_port_arbiter_if.sv
// Bundle between the per-channel data-service blocks and the data-memory port arbiter.
// The watchdog error line exists only when MPU_DMEM_ARB_WDT_EN is defined.
interface mpu_dmem_port_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int WIDTH_SEL = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   I_Req;
    logic [NUM_REQ-1:0]   I_Dir;
    logic [NUM_REQ-1:0]   I_Rls;
    logic [NUM_REQ-1:0]   O_Grant;
    logic                 O_Mem_Busy;
    logic [WIDTH_SEL-1:0] O_Mem_Owner;
    logic                 O_Mem_Dir;
`ifdef MPU_DMEM_ARB_WDT_EN
    logic                 O_Wdt_Err;
`endif

    modport master (
        input  I_Req, I_Dir, I_Rls,
        output O_Grant, O_Mem_Busy, O_Mem_Owner, O_Mem_Dir
`ifdef MPU_DMEM_ARB_WDT_EN
        , output O_Wdt_Err
`endif
    );

    modport slave (
        output I_Req, I_Dir, I_Rls,
        input  O_Grant, O_Mem_Busy, O_Mem_Owner, O_Mem_Dir
`ifdef MPU_DMEM_ARB_WDT_EN
        , input O_Wdt_Err
`endif
    );
endinterface

// File: rtl/mpu_dmem_port_arbiter.sv
// Round-robin owner of the MPU data-memory port: grant pulse, hold until release, one turnaround cycle.
// Optional ownership watchdog is compiled in with MPU_DMEM_ARB_WDT_EN.
module mpu_dmem_port_arbiter #(
    parameter int NUM_REQ = 4
`ifdef MPU_DMEM_ARB_WDT_EN
    , parameter int WDT_LIMIT = 1024
`endif
) (
    input  logic clock,
    input  logic reset,
    mpu_dmem_port_arbiter_if.master bus
);
    localparam int WIDTH_SEL = $clog2(NUM_REQ);
    localparam logic [WIDTH_SEL-1:0] LAST_IDX     = WIDTH_SEL'(NUM_REQ - 1);
    localparam logic [WIDTH_SEL-1:0] IDX_ONE      = WIDTH_SEL'(1);
    localparam logic [WIDTH_SEL:0]   NUM_REQ_W    = (WIDTH_SEL + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0]   ONE_HOT_BASE = {{(NUM_REQ-1){1'b0}}, 1'b1};
`ifdef MPU_DMEM_ARB_WDT_EN
    localparam int CNT_W = $clog2(WDT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [WIDTH_SEL-1:0] owner_r, owner_s;
    logic [WIDTH_SEL-1:0] rr_ptr_r, rr_ptr_s;
    logic                 dir_r, dir_s;
    logic [NUM_REQ-1:0]   grant_r, grant_s;
    logic                 busy_r, busy_s;
    logic [WIDTH_SEL:0]   pick_s;
`ifdef MPU_DMEM_ARB_WDT_EN
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 wdt_err_r, wdt_err_s;
`endif

    // MSB flags a hit; lower bits give the first requester at or after ptr, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite the others.
    function automatic logic [WIDTH_SEL:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [WIDTH_SEL-1:0] ptr);
        logic [WIDTH_SEL:0] idx;
        logic [WIDTH_SEL:0] res;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + i[WIDTH_SEL:0];
            if (idx >= NUM_REQ_W) begin
                idx = idx - NUM_REQ_W;
            end else begin
                idx = idx;
            end
            if (req[idx[WIDTH_SEL-1:0]]) begin
                res = {1'b1, idx[WIDTH_SEL-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_s  = state_r;
        owner_s  = owner_r;
        dir_s    = dir_r;
        rr_ptr_s = rr_ptr_r;
        grant_s  = '0;
        busy_s   = 1'b0;
        pick_s   = rr_pick(bus.I_Req, rr_ptr_r);
`ifdef MPU_DMEM_ARB_WDT_EN
        cnt_s     = cnt_r;
        wdt_err_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (pick_s[WIDTH_SEL]) begin
                    state_s = ST_GRANT;
                    owner_s = pick_s[WIDTH_SEL-1:0];
                    dir_s   = bus.I_Dir[pick_s[WIDTH_SEL-1:0]];
                    grant_s = ONE_HOT_BASE << pick_s[WIDTH_SEL-1:0];
                    busy_s  = 1'b1;
`ifdef MPU_DMEM_ARB_WDT_EN
                    cnt_s   = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (bus.I_Rls[owner_r]) begin
                    state_s = ST_TURN;
                end else begin
                    state_s = ST_BUSY;
                    busy_s  = 1'b1;
                end
            end
            ST_BUSY: begin
                // A release in the limit cycle wins over the watchdog.
                if (bus.I_Rls[owner_r]) begin
                    state_s = ST_TURN;
                end
`ifdef MPU_DMEM_ARB_WDT_EN
                else if (cnt_r == CNT_LAST) begin
                    state_s   = ST_TURN;
                    wdt_err_s = 1'b1;
                end
`endif
                else begin
                    state_s = ST_BUSY;
                    busy_s  = 1'b1;
`ifdef MPU_DMEM_ARB_WDT_EN
                    cnt_s   = cnt_r + CNT_ONE;
`endif
                end
            end
            ST_TURN: begin
                state_s  = ST_IDLE;
                rr_ptr_s = (owner_r == LAST_IDX) ? '0 : owner_r + IDX_ONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops ownership without side effects.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            owner_r   <= '0;
            dir_r     <= 1'b0;
            rr_ptr_r  <= '0;
            grant_r   <= '0;
            busy_r    <= 1'b0;
`ifdef MPU_DMEM_ARB_WDT_EN
            cnt_r     <= '0;
            wdt_err_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            dir_r     <= dir_s;
            rr_ptr_r  <= rr_ptr_s;
            grant_r   <= grant_s;
            busy_r    <= busy_s;
`ifdef MPU_DMEM_ARB_WDT_EN
            cnt_r     <= cnt_s;
            wdt_err_r <= wdt_err_s;
`endif
        end
    end

    assign bus.O_Grant     = grant_r;
    assign bus.O_Mem_Busy  = busy_r;
    assign bus.O_Mem_Owner = owner_r;
    assign bus.O_Mem_Dir   = dir_r;
`ifdef MPU_DMEM_ARB_WDT_EN
    assign bus.O_Wdt_Err   = wdt_err_r;
`endif
endmodule

// File: tb/tb_mpu_dmem_port_arbiter.sv
// Bench for mpu_dmem_port_arbiter: directed corner cases, then randomized channels
// checked by a scoreboard fed from a transaction-level round-robin model.
module tb_mpu_dmem_port_arbiter;
    localparam int N = 4;

    logic clock;
    logic reset;

    mpu_dmem_port_arbiter_if #(.NUM_REQ(N)) bus ();

    mpu_dmem_port_arbiter #(.NUM_REQ(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int   cyc;
        int   owner;
        logic dir;
    } exp_t;

    exp_t gq[$];
    int   rq[$];

    int n_chk;
    int n_err;
    int cyc;
    bit sb_on;
    bit busy_prev;

    logic [N-1:0] pend;
    logic [N-1:0] pdir;
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_idle_from;
    int grant_at;
    int rls_at;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d,
                         input logic [N-1:0] l);
        @(posedge clock);
        #1;
        reset      = rst;
        bus.I_Req  = r;
        bus.I_Dir  = d;
        bus.I_Rls  = l;
        @(negedge clock);
    endtask

    task automatic chk_out(input string name, input int g, input int b, input int o, input int d);
        chk({name, "_grant"}, int'(bus.O_Grant), g);
        chk({name, "_busy"}, int'(bus.O_Mem_Busy), b);
        chk({name, "_owner"}, int'(bus.O_Mem_Owner), o);
        chk({name, "_dir"}, int'(bus.O_Mem_Dir), d);
    endtask

    // One scoreboard cycle: channel behaviour plus the round-robin model's predictions.
    task automatic sb_run(input int ncyc, input bit hold, input int fixed_d, input bit gen);
        logic [N-1:0] rls_v;
        logic [N-1:0] own_bit;
        int o;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clock);
            #1;
            cyc++;
            rls_v = '0;
            if (m_busy && cyc == grant_at && !hold) pend[m_owner] = 1'b0;
            if (!hold && gen) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && !(m_busy && i == m_owner) && $urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        pdir[i] = 1'($urandom_range(0, 1));
                    end
                end
            end
            if (m_busy) begin
                own_bit = '0;
                own_bit[m_owner] = 1'b1;
                if (!hold) rls_v = N'($urandom_range(0, 15)) & ~own_bit;
                if (cyc == rls_at) begin
                    rls_v       = rls_v | own_bit;
                    rq.push_back(cyc + 1);
                    m_busy      = 1'b0;
                    m_idle_from = cyc + 2;
                    m_ptr       = (m_owner + 1) % N;
                end
            end else if (cyc >= m_idle_from && pend != '0) begin
                o = -1;
                for (int j = 0; j < N; j++) begin
                    if (o < 0 && pend[(m_ptr + j) % N]) o = (m_ptr + j) % N;
                end
                gq.push_back('{cyc + 1, o, pdir[o]});
                m_busy   = 1'b1;
                m_owner  = o;
                grant_at = cyc + 1;
                rls_at   = cyc + 1 + ((fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4)));
            end
            bus.I_Req = pend;
            bus.I_Dir = pdir;
            bus.I_Rls = rls_v;
        end
    endtask

    // Scoreboard monitor: compares grant pulses and busy falls against queued predictions.
    always @(negedge clock) begin
        if (sb_on) begin
            if (bus.O_Grant != '0) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", int'(bus.O_Grant), 0);
                end else begin
                    exp_t e;
                    logic [N-1:0] oh;
                    e  = gq.pop_front();
                    oh = '0;
                    oh[e.owner] = 1'b1;
                    chk("grant_cycle", cyc, e.cyc);
                    chk("grant_vec", int'(bus.O_Grant), int'(oh));
                    chk("grant_owner", int'(bus.O_Mem_Owner), e.owner);
                    chk("grant_dir", int'(bus.O_Mem_Dir), int'(e.dir));
                    chk("grant_busy", int'(bus.O_Mem_Busy), 1);
                end
            end else if (gq.size() > 0 && gq[0].cyc < cyc) begin
                chk("grant_missing", cyc, gq[0].cyc);
                void'(gq.pop_front());
            end
            if (busy_prev && !bus.O_Mem_Busy) begin
                if (rq.size() == 0) begin
                    chk("release_unexpected", cyc, -1);
                end else begin
                    chk("release_cycle", cyc, rq.pop_front());
                end
            end else if (rq.size() > 0 && rq[0] < cyc) begin
                chk("release_missing", cyc, rq[0]);
                void'(rq.pop_front());
            end
            busy_prev = bus.O_Mem_Busy;
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        sb_on = 1'b0;
        busy_prev = 1'b0;
        reset = 1'b1;
        bus.I_Req = '0;
        bus.I_Dir = '0;
        bus.I_Rls = '0;
        repeat (3) drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk_out("reset", 0, 0, 0, 0);

        // Single store request from channel 0, then release.
        drive(1'b0, 4'b0001, 4'b0001, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0001, 4'b0000);
        chk_out("t1_grant", 1, 1, 0, 1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk_out("t1_busy", 0, 1, 0, 1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0001);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk("t1_release_busy", int'(bus.O_Mem_Busy), 0);

        // Owner 2 ignores a foreign release; its own release advances the pointer to 3.
        drive(1'b0, 4'b0100, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk_out("t3_grant", 4, 1, 2, 0);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0001);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk_out("t3_foreign_rls", 0, 1, 2, 0);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0100);
        drive(1'b0, 4'b1011, 4'b0000, 4'b0000);
        chk_out("t3_turn", 0, 0, 2, 0);
        drive(1'b0, 4'b1011, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0011, 4'b0000, 4'b1000);
        chk_out("t3_ptr3_grant", 8, 1, 3, 0);

        // Zero-length access: release in the grant cycle.
        drive(1'b0, 4'b0011, 4'b0000, 4'b0000);
        chk("t4_busy_one_cycle", int'(bus.O_Mem_Busy), 0);
        drive(1'b0, 4'b0011, 4'b0000, 4'b0000);
        chk_out("t4_idle", 0, 0, 3, 0);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk_out("t4_wrap_grant", 1, 1, 0, 0);

        // Reset while busy, then a request from channel 3 only.
        drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
        chk("t5_busy_before_reset", int'(bus.O_Mem_Busy), 1);
        drive(1'b0, 4'b1000, 4'b1000, 4'b0000);
        chk_out("t5_after_reset", 0, 0, 0, 0);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk_out("t5_regrant", 8, 1, 3, 1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b1000);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);

        // Scoreboard phase: all requests held (fairness), then random traffic.
        m_busy      = 1'b0;
        m_owner     = 0;
        m_ptr       = 0;
        m_idle_from = 0;
        grant_at    = 0;
        rls_at      = -1;
        pend        = 4'b1111;
        pdir        = N'($urandom_range(0, 15));
        busy_prev   = 1'b0;
        sb_on       = 1'b1;
        sb_run(33, 1'b1, 3, 1'b0);
        sb_run(600, 1'b0, -1, 1'b1);
        for (int k = 0; k < 60 && (m_busy || pend != '0); k++) begin
            sb_run(1, 1'b0, -1, 1'b0);
        end
        chk("drain_model_idle", int'(m_busy), 0);
        sb_run(8, 1'b0, -1, 1'b0);
        chk("grant_queue_empty", gq.size(), 0);
        chk("release_queue_empty", rq.size(), 0);
        sb_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mpu_dmem_port_arbiter.md
Name: mpu_dmem_port_arbiter

Overview:
- Round-robin arbiter that shares the single MPU data-memory access port among NUM_REQ data-service channels.
- Each channel requests a load or store burst. The arbiter issues a one-cycle grant pulse and holds ownership until the owner releases.
- It then inserts a one-cycle turnaround before re-arbitrating.
- Sits between the per-channel data-service blocks and the data-memory port mux; drives the mux select and direction.

Parameters:
- NUM_REQ, 4, number of requesting channels (>=2).
- WIDTH_SEL, $clog2(NUM_REQ), owner index width (derived, not overridden).

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- I_Req  in  NUM_REQ  per-channel access request, level; held until granted
- I_Dir  in  NUM_REQ  per-channel direction, 1 = store to memory, 0 = load from memory; sampled with I_Req
- I_Rls  in  NUM_REQ  per-channel end-of-access pulse
- O_Grant  out  NUM_REQ  one-hot, one-cycle grant pulse
- O_Mem_Busy  out  1  port owned (GRANT or BUSY state)
- O_Mem_Owner  out  WIDTH_SEL  index of current owner; port mux select
- O_Mem_Dir  out  1  latched direction of current owner
- O_Wdt_Err  out  1  watchdog error pulse; exists only with the optional feature

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock. State=IDLE, RR_Ptr=0; O_Grant=0, O_Mem_Busy=0, O_Mem_Owner=0, O_Mem_Dir=0, O_Wdt_Err=0.
- Reset mid-operation: abandons ownership immediately, with no grant or release side-effects.
- IDLE:
  - If any I_Req bit is set, select the first set bit scanning RR_Ptr, RR_Ptr+1, ..., wrapping mod NUM_REQ.
  - Register Owner and Dir=I_Dir[Owner], then go to GRANT. Otherwise stay in IDLE.
- GRANT (1 cycle):
  - O_Grant[Owner]=1, O_Mem_Busy=1.
  - If I_Rls[Owner] in this cycle, go to TURN (zero-length access); else go to BUSY.
- BUSY:
  - O_Mem_Busy=1, O_Mem_Owner and O_Mem_Dir stable.
  - Leave only on I_Rls[Owner]=1, going to TURN.
  - I_Rls from non-owners is ignored. Owner dropping I_Req is ignored.
- TURN (1 cycle):
  - O_Mem_Busy=0.
  - RR_Ptr <= (Owner+1) mod NUM_REQ; with NUM_REQ not a power of two, wrap explicitly.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle t gives grant pulse at t+1. Release at t gives Busy low at t+1; earliest next grant is t+3.
- Fairness: with all requests continuously high, grants rotate 0,1,2,3,0,...
- O_Mem_Owner holds its last value outside GRANT/BUSY.
- O_Grant is registered from state; no combinational path from I_Req to O_Grant.
- Illegal state encoding: recover to IDLE.

Optional Feature:
- Macro: MPU_DMEM_ARB_WDT_EN.
- Enabled:
  - Adds parameter WDT_LIMIT (default 1024) and a cycle counter that clears on entry to GRANT and increments each BUSY cycle.
  - When the counter reaches WDT_LIMIT without I_Rls[Owner], force TURN and pulse O_Wdt_Err for 1 cycle, in the same cycle Busy deasserts.
  - Simultaneous I_Rls[Owner] and limit reached: treat as normal release, no error.
- Disabled: no counter, no O_Wdt_Err port; ownership is unbounded.

Test Plan:
1. Reset then I_Req=0001, I_Dir=0001 -> O_Grant=0001 one cycle later; O_Mem_Busy=1, O_Mem_Owner=0, O_Mem_Dir=1; after I_Rls=0001, Busy=0 next cycle.
2. I_Req=1111 held, each owner releases 3 cycles after grant -> grant order 0,1,2,3,0; 6 cycles between consecutive grant pulses.
3. Owner 2 in BUSY, I_Rls=0001 (non-owner) -> no state change, Owner stays 2; I_Rls=0100 -> TURN, RR_Ptr=3.
4. I_Rls[Owner] asserted in GRANT cycle -> Busy high exactly 1 cycle, next arbitration follows TURN.
5. reset asserted in BUSY -> all outputs 0 next cycle; re-request 1000 -> grant 1000 (RR_Ptr=0 scan reaches 3).
6. With MPU_DMEM_ARB_WDT_EN, WDT_LIMIT=8, owner never releases -> O_Wdt_Err pulse 8 BUSY cycles after grant; Busy drops the same cycle; next requester is granted.
